// File: rtl/picmicro_pkg.sv
// Shared constants for the PIC-style interrupt controller: INTCON bit
// positions, the interrupt vector address and the sequencer state encoding.
package picmicro_pkg;

  localparam int unsigned INTCON_GIE  = 7;
  localparam int unsigned INTCON_PEIE = 6;
  localparam int unsigned INTCON_T0IE = 5;
  localparam int unsigned INTCON_INTE = 4;
  localparam int unsigned INTCON_RBIE = 3;
  localparam int unsigned INTCON_T0IF = 2;
  localparam int unsigned INTCON_INTF = 1;
  localparam int unsigned INTCON_RBIF = 0;

  // Address the core loads into the PC when pc_vector_en strobes.
  localparam logic [12:0] ISR_VECTOR = 13'h0004;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_ISR    = 2'd3
  } irq_state_t;

endpackage

// File: rtl/picmicro_edge_detect.sv
// Selectable-polarity edge detector for the external INT pin. The edge is
// suppressed until the pin history register holds a real post-reset sample,
// so a pin already at its active level at reset release does not fire.
module picmicro_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic intedg,
  output logic edge_pulse
);

  logic r_pin_q;
  logic r_valid;
  logic w_rise;
  logic w_fall;

  // Register the previous pin sample and mark it valid after the first clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_q <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_pin_q <= pin;
      r_valid <= 1'b1;
    end
  end

  // Compare the live pin against its history and pick the configured edge.
  always_comb begin
    w_rise     = pin & ~r_pin_q;
    w_fall     = ~pin & r_pin_q;
    edge_pulse = r_valid & (intedg ? w_rise : w_fall);
  end

endmodule

// File: rtl/picmicro_interrupt_controller.sv
// PIC16-style interrupt controller: owns INTCON, latches event flags, and
// sequences the vector to 0x0004 on an unflushed instruction-cycle boundary.
//
// Strobe semantics: there is no valid/ready handshake here. pc_vector_en is a
// single-clk command the core must act on in that clk (push PC, load the
// vector, flush). retfie_exec and the event inputs are sampled every clk and
// are acted on in the clk they are high; the core never back-pressures.
module picmicro_interrupt_controller
  import picmicro_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       q_end,
  input  logic       instr_flush,
  input  logic       intcon_wr_en,
  input  logic [7:0] intcon_wr_data,
  output logic [7:0] intcon_out,
  input  logic       int_pin,
  input  logic       intedg,
  input  logic       tmr0_overflow,
  input  logic       rb_change,
  input  logic       periph_irq,
  input  logic       retfie_exec,
  output logic       pc_vector_en,
  output logic       in_isr,
  output logic       wake,
  output logic [1:0] dbg_state
);

  logic [7:0] r_intcon;
  logic [7:0] w_intcon_nxt;
  irq_state_t r_state;
  irq_state_t w_state_nxt;
  logic       w_int_edge;
  logic       w_any_enabled;
  logic       w_pending;

  picmicro_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin        (int_pin),
    .intedg     (intedg),
    .edge_pulse (w_int_edge)
  );

  // Interrupt request terms: wake ignores GIE, vectoring requires it.
  always_comb begin
    w_any_enabled = (r_intcon[INTCON_T0IE] & r_intcon[INTCON_T0IF])
                  | (r_intcon[INTCON_INTE] & r_intcon[INTCON_INTF])
                  | (r_intcon[INTCON_RBIE] & r_intcon[INTCON_RBIF])
                  | (r_intcon[INTCON_PEIE] & periph_irq);
    w_pending     = r_intcon[INTCON_GIE] & w_any_enabled;
  end

  // INTCON next value: software write first, then hardware overrides.
  // The VECTOR clear of GIE is applied last so it beats both a software
  // write and a coincident RETFIE.
  always_comb begin
    w_intcon_nxt = r_intcon;
    if (intcon_wr_en) begin
      w_intcon_nxt = intcon_wr_data;
    end
    if (tmr0_overflow) begin
      w_intcon_nxt[INTCON_T0IF] = 1'b1;
    end
    if (rb_change) begin
      w_intcon_nxt[INTCON_RBIF] = 1'b1;
    end
    if (w_int_edge) begin
      w_intcon_nxt[INTCON_INTF] = 1'b1;
    end
    if (retfie_exec) begin
      w_intcon_nxt[INTCON_GIE] = 1'b1;
    end
    if (r_state == ST_VECTOR) begin
      w_intcon_nxt[INTCON_GIE] = 1'b0;
    end
  end

  // Sequencer transitions; ARMED re-checks pending every clk so a GIE clear
  // by firmware cancels the request before the boundary is reached.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!w_pending) begin
          w_state_nxt = ST_IDLE;
        end else if (q_end && !instr_flush) begin
          w_state_nxt = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        w_state_nxt = ST_ISR;
      end
      ST_ISR: begin
        if (retfie_exec) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and INTCON registers, both cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_intcon <= 8'h00;
      r_state  <= ST_IDLE;
    end else begin
      r_intcon <= w_intcon_nxt;
      r_state  <= w_state_nxt;
    end
  end

  // Outputs decode directly from registered state, so reset forces them low
  // immediately and the vector strobe is exactly one clk wide.
  always_comb begin
    intcon_out   = r_intcon;
    pc_vector_en = (r_state == ST_VECTOR);
    in_isr       = (r_state == ST_ISR);
    wake         = w_any_enabled;
    dbg_state    = r_state;
  end

endmodule

// File: tb/tb_picmicro_interrupt_controller.sv
// Directed bench for the interrupt controller: each step drives inputs just
// after a rising edge and checks outputs against hand-computed values.
module tb_picmicro_interrupt_controller;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_VECTOR = 2'd2;
  localparam logic [1:0] S_ISR    = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       q_end;
  logic       instr_flush;
  logic       intcon_wr_en;
  logic [7:0] intcon_wr_data;
  logic [7:0] intcon_out;
  logic       int_pin;
  logic       intedg;
  logic       tmr0_overflow;
  logic       rb_change;
  logic       periph_irq;
  logic       retfie_exec;
  logic       pc_vector_en;
  logic       in_isr;
  logic       wake;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;
  int vec_count;

  picmicro_interrupt_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .q_end          (q_end),
    .instr_flush    (instr_flush),
    .intcon_wr_en   (intcon_wr_en),
    .intcon_wr_data (intcon_wr_data),
    .intcon_out     (intcon_out),
    .int_pin        (int_pin),
    .intedg         (intedg),
    .tmr0_overflow  (tmr0_overflow),
    .rb_change      (rb_change),
    .periph_irq     (periph_irq),
    .retfie_exec    (retfie_exec),
    .pc_vector_en   (pc_vector_en),
    .in_isr         (in_isr),
    .wake           (wake),
    .dbg_state      (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clk and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_intcon(input logic [7:0] d);
    intcon_wr_en   = 1'b1;
    intcon_wr_data = d;
    tick();
    intcon_wr_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; q_end = 1'b0; instr_flush = 1'b0;
    intcon_wr_en = 1'b0; intcon_wr_data = 8'h00;
    int_pin = 1'b0; intedg = 1'b0; tmr0_overflow = 1'b0;
    rb_change = 1'b0; periph_irq = 1'b0; retfie_exec = 1'b0;

    // Reset state
    #2;
    check("rst_intcon", 16'(intcon_out), 16'h00);
    check("rst_state", 16'(dbg_state), 16'(S_IDLE));
    check("rst_vec", 16'(pc_vector_en), 16'h0);
    check("rst_isr", 16'(in_isr), 16'h0);
    check("rst_wake", 16'(wake), 16'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Timer interrupt: arm, vector on unflushed q_end, enter ISR
    wr_intcon(8'hA0);
    check("t1_wr", 16'(intcon_out), 16'hA0);
    tmr0_overflow = 1'b1;
    tick();
    tmr0_overflow = 1'b0;
    check("t1_t0if", 16'(intcon_out), 16'hA4);
    check("t1_idle", 16'(dbg_state), 16'(S_IDLE));
    tick();
    check("t1_armed", 16'(dbg_state), 16'(S_ARMED));
    check("t1_novec", 16'(pc_vector_en), 16'h0);
    q_end = 1'b1;
    tick();
    q_end = 1'b0;
    check("t1_vec", 16'(pc_vector_en), 16'h1);
    check("t1_vstate", 16'(dbg_state), 16'(S_VECTOR));
    tick();
    check("t1_vec_off", 16'(pc_vector_en), 16'h0);
    check("t1_intcon", 16'(intcon_out), 16'h24);
    check("t1_in_isr", 16'(in_isr), 16'h1);

    // Clear T0IF in ISR then RETFIE
    wr_intcon(8'h20);
    check("t2_clr", 16'(intcon_out), 16'h20);
    check("t2_hold", 16'(in_isr), 16'h1);
    retfie_exec = 1'b1; q_end = 1'b1;
    tick();
    retfie_exec = 1'b0; q_end = 1'b0;
    check("t2_intcon", 16'(intcon_out), 16'hA0);
    check("t2_state", 16'(dbg_state), 16'(S_IDLE));
    check("t2_isr_off", 16'(in_isr), 16'h0);
    vec_count = 0;
    for (int i = 0; i < 4; i++) begin
      q_end = (i % 2 == 1);
      tick();
      if (pc_vector_en) vec_count++;
    end
    q_end = 1'b0;
    check("t2_no_revec", 16'(vec_count), 16'h0);

    // Software write coinciding with the VECTOR GIE clear loses
    tmr0_overflow = 1'b1;
    tick();
    tmr0_overflow = 1'b0;
    tick();
    q_end = 1'b1;
    tick();
    q_end = 1'b0;
    check("t3_vec", 16'(pc_vector_en), 16'h1);
    wr_intcon(8'hA4);
    check("t3_gie_lost", 16'(intcon_out), 16'h24);
    check("t3_isr", 16'(dbg_state), 16'(S_ISR));
    wr_intcon(8'h20);
    retfie_exec = 1'b1;
    tick();
    retfie_exec = 1'b0;
    check("t3_ret", 16'(intcon_out), 16'hA0);

    // Falling INT edge, flushed q_end must not vector
    int_pin = 1'b1;
    wr_intcon(8'h90);
    check("t4_wr", 16'(intcon_out), 16'h90);
    int_pin = 1'b0; q_end = 1'b1; instr_flush = 1'b1;
    tick();
    check("t4_intf", 16'(intcon_out), 16'h92);
    tick();
    check("t4_armed", 16'(dbg_state), 16'(S_ARMED));
    check("t4_flush0", 16'(pc_vector_en), 16'h0);
    tick();
    check("t4_flush1", 16'(pc_vector_en), 16'h0);
    check("t4_still", 16'(dbg_state), 16'(S_ARMED));
    instr_flush = 1'b0;
    tick();
    q_end = 1'b0;
    check("t4_vec", 16'(pc_vector_en), 16'h1);
    tick();
    check("t4_isr", 16'(intcon_out), 16'h12);
    wr_intcon(8'h10);
    retfie_exec = 1'b1;
    tick();
    retfie_exec = 1'b0;
    check("t4_ret", 16'(intcon_out), 16'h90);

    // Hardware set beats software write of 0; T0IE off so no vector
    intcon_wr_en = 1'b1; intcon_wr_data = 8'h80; tmr0_overflow = 1'b1;
    tick();
    intcon_wr_en = 1'b0; tmr0_overflow = 1'b0;
    check("t5_setwins", 16'(intcon_out), 16'h84);
    check("t5_wake", 16'(wake), 16'h0);
    vec_count = 0;
    for (int i = 0; i < 3; i++) begin
      q_end = 1'b1;
      tick();
      if (pc_vector_en) vec_count++;
    end
    q_end = 1'b0;
    check("t5_novec", 16'(vec_count), 16'h0);
    check("t5_idle", 16'(dbg_state), 16'(S_IDLE));

    // GIE=0 with enabled INTF: wake only
    wr_intcon(8'h12);
    check("t6_intcon", 16'(intcon_out), 16'h12);
    check("t6_wake", 16'(wake), 16'h1);
    vec_count = 0;
    for (int i = 0; i < 6; i++) begin
      q_end = (i % 2 == 0);
      tick();
      if (pc_vector_en) vec_count++;
    end
    q_end = 1'b0;
    check("t6_novec", 16'(vec_count), 16'h0);
    check("t6_idle", 16'(dbg_state), 16'(S_IDLE));

    // Peripheral request arms, then GIE cleared before the boundary
    periph_irq = 1'b1;
    wr_intcon(8'hC0);
    check("t7_wake", 16'(wake), 16'h1);
    tick();
    check("t7_armed", 16'(dbg_state), 16'(S_ARMED));
    wr_intcon(8'h40);
    check("t7_gie_off", 16'(intcon_out), 16'h40);
    q_end = 1'b1;
    tick();
    q_end = 1'b0;
    check("t7_drop", 16'(dbg_state), 16'(S_IDLE));
    check("t7_novec", 16'(pc_vector_en), 16'h0);
    periph_irq = 1'b0;
    #1;
    check("t7_wake_off", 16'(wake), 16'h0);

    // RETFIE outside ISR sets GIE only; rb_change sets RBIF
    retfie_exec = 1'b1;
    tick();
    retfie_exec = 1'b0;
    check("t8_gie", 16'(intcon_out), 16'hC0);
    check("t8_idle", 16'(dbg_state), 16'(S_IDLE));
    rb_change = 1'b1;
    tick();
    rb_change = 1'b0;
    check("t8_rbif", 16'(intcon_out), 16'hC1);

    // Reset during ISR; pin high at release with rising edge select
    periph_irq = 1'b1;
    tick();
    tick();
    q_end = 1'b1;
    tick();
    q_end = 1'b0;
    tick();
    check("t9_in_isr", 16'(in_isr), 16'h1);
    rst_n = 1'b0;
    #1;
    check("t9_rst_intcon", 16'(intcon_out), 16'h00);
    check("t9_rst_isr", 16'(in_isr), 16'h0);
    check("t9_rst_state", 16'(dbg_state), 16'(S_IDLE));
    periph_irq = 1'b0; int_pin = 1'b1; intedg = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t9_no_intf0", 16'(intcon_out), 16'h00);
    tick();
    check("t9_no_intf1", 16'(intcon_out), 16'h00);
    check("t9_novec", 16'(pc_vector_en), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/picmicro_interrupt_controller.md
PICMICRO_INTERRUPT_CONTROLLER -- requirements
Module: picmicro_interrupt_controller

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-002 SHALL provide q_end in 1: high for one clk on the last Q-cycle of each instruction cycle.
REQ-003 SHALL provide instr_flush in 1: current instruction cycle is a flushed slot (second cycle of GOTO, CALL, RETURN, RETLW or RETFIE).
REQ-004 SHALL provide intcon_wr_en in 1 and intcon_wr_data in 8: core write to INTCON, already address-decoded.
REQ-005 SHALL provide intcon_out out 8: current INTCON value for core reads.
REQ-006 SHALL provide int_pin in 1, a synchronised external INT pin, and intedg in 1: 1 selects rising edge, 0 selects falling edge.
REQ-007 SHALL provide tmr0_overflow in 1, rb_change in 1 and periph_irq in 1 as single-cycle event pulses or levels.
REQ-008 SHALL provide retfie_exec in 1: core has decoded RETFIE, qualified with q_end.
REQ-009 SHALL provide pc_vector_en out 1: one-clk strobe telling the core to push the PC, load 13'h0004 and flush the pipeline.
REQ-010 SHALL provide in_isr out 1 (handler active) and wake out 1 (sleep wake request).

Function
REQ-011 INTCON layout SHALL be [7]GIE [6]PEIE [5]T0IE [4]INTE [3]RBIE [2]T0IF [1]INTF [0]RBIF.
REQ-012 Flags SHALL set on events: T0IF on tmr0_overflow, RBIF on rb_change, INTF on the selected int_pin edge.
REQ-013 A hardware flag set SHALL win over a software write of 0 to the same bit in the same clk; all other bits take intcon_wr_data on intcon_wr_en.
REQ-014 Edge detection SHALL compare int_pin with a registered copy; no edge SHALL be reported in the first clk after reset release.
REQ-015 Pending SHALL be GIE & ((T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (PEIE&periph_irq)).
REQ-016 wake SHALL equal the same OR term without GIE, combinationally.
REQ-017 FSM states SHALL be IDLE, ARMED, VECTOR and ISR.
REQ-018 IDLE SHALL go to ARMED when pending is 1.
REQ-019 ARMED SHALL go to VECTOR on q_end with instr_flush=0, and SHALL return to IDLE if pending drops (for example GIE cleared by software) before that.
REQ-020 VECTOR SHALL last exactly one clk with pc_vector_en=1, clear GIE on that edge, then enter ISR.
REQ-021 ISR SHALL hold in_isr=1 and ignore pending.
REQ-022 retfie_exec in ISR SHALL set GIE and return to IDLE; if a flag is still enabled, ARMED SHALL follow on the next clk (back-to-back interrupts).
REQ-023 A software write in the same clk as the VECTOR GIE clear SHALL lose: GIE stays 0.
REQ-024 retfie_exec outside ISR SHALL still set GIE (firmware-emulated return) without changing state.
REQ-025 Latency SHALL be deterministic: pc_vector_en asserts exactly 1 clk after the qualifying q_end.

Reset
REQ-026 On rst_n=0, asynchronously: INTCON=8'h00, state=IDLE, edge register=0, edge-valid=0, pc_vector_en=0, in_isr=0.
REQ-027 Reset asserted in any state, including VECTOR or ISR, SHALL abort to IDLE with no further strobe.

Structure
REQ-028 Package picmicro_pkg SHALL hold the INTCON bit index constants, ISR_VECTOR=13'h0004 and the FSM state enum.
REQ-029 Pin edge detection SHALL live in one sub-module, picmicro_edge_detect (inputs clk, rst_n, pin, intedg; output edge pulse).
REQ-030 Target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-031 Write INTCON=8'hA0, pulse tmr0_overflow, next q_end with instr_flush=0 -> T0IF=1, pc_vector_en one clk later, INTCON=8'h24, in_isr=1.
REQ-032 In ISR, write INTCON=8'h20 (clear T0IF), then retfie_exec -> INTCON=8'hA0, state IDLE, no re-vector.
REQ-033 INTCON=8'h90, intedg=0, int_pin 1->0 while q_end coincides with instr_flush=1 -> no vector that cycle; vector at the next unflushed q_end.
REQ-034 INTCON=8'h80 with tmr0_overflow in the same clk as intcon_wr_data=8'h80 -> T0IF=1 (set wins), no vector (T0IE=0), wake=0.
REQ-035 GIE=0, INTE=1, INTF set -> wake=1, pc_vector_en never asserts.
REQ-036 rst_n low during ISR -> INTCON=8'h00, in_isr=0 immediately; int_pin held high at release, intedg=1 -> no INTF.
